// File: rtl/stun_controller_if.sv
// stun_controller_if: bomb/player inputs and per-player stun status outputs of stun_controller
interface stun_controller_if #(
  parameter int NUM_PLAYERS = 2,
  parameter int COORD_W = 6
);
  logic bomb_valid;
  logic [COORD_W-1:0] bomb_x, bomb_y;
  logic [NUM_PLAYERS*COORD_W-1:0] player_x, player_y;
  logic [NUM_PLAYERS-1:0] stun_active, stun_start, immune;
  modport master (
    output bomb_valid, bomb_x, bomb_y, player_x, player_y,
    input  stun_active, stun_start, immune
  );
  modport slave (
    input  bomb_valid, bomb_x, bomb_y, player_x, player_y,
    output stun_active, stun_start, immune
  );
endinterface

// File: rtl/stun_controller.sv
// stun_controller: square-radius blast hit test and per-player stun timer.
// Defining STUN_IMMUNITY_EN adds a post-stun immunity window during which hits are ignored.
module stun_controller #(
  parameter int NUM_PLAYERS = 2,
  parameter int COORD_W = 6,
  parameter int RADIUS = 1,
  parameter int STUN_CYCLES = 250000000,
  parameter int IMMUNE_CYCLES = 100000000,
  parameter int CNT_W = 28
) (
  input logic clk,
  input logic resetn,
  stun_controller_if.slave bus
);
  typedef enum logic [1:0] {IDLE, STUNNED, IMMUNE} state_t;
  localparam logic [COORD_W:0] RAD = (COORD_W+1)'(RADIUS);
  localparam logic [CNT_W-1:0] STUN_LOAD = CNT_W'(STUN_CYCLES - 1);
`ifdef STUN_IMMUNITY_EN
  localparam logic [CNT_W-1:0] IMM_LOAD = CNT_W'(IMMUNE_CYCLES - 1);
`endif
  if (STUN_CYCLES < 1 || IMMUNE_CYCLES < 1) begin : gBadCfg
    $error("stun_controller: STUN_CYCLES and IMMUNE_CYCLES must be >= 1");
  end
  logic [NUM_PLAYERS-1:0] stunActive, stunStart, immune;
  for (genvar i = 0; i < NUM_PLAYERS; i++) begin : gPlayer
    logic [COORD_W-1:0] px, py;
    logic [COORD_W:0] dx, dy;
    logic hit, startNext, startQ;
    state_t state, stateNext;
    logic [CNT_W-1:0] cnt, cntNext;
    assign px = bus.player_x[i*COORD_W +: COORD_W];
    assign py = bus.player_y[i*COORD_W +: COORD_W];
    // absolute distances without wrap-around: the grid edges are not adjacent
    assign dx = px >= bus.bomb_x ? {1'b0, px - bus.bomb_x} : {1'b0, bus.bomb_x - px};
    assign dy = py >= bus.bomb_y ? {1'b0, py - bus.bomb_y} : {1'b0, bus.bomb_y - py};
    assign hit = bus.bomb_valid && dx <= RAD && dy <= RAD;
    always_comb begin
      stateNext = state;
      cntNext = cnt;
      startNext = 1'b0;
      case (state)
        IDLE: begin
          stateNext = hit ? STUNNED : IDLE;
          cntNext = hit ? STUN_LOAD : cnt;
          startNext = hit;
        end
        STUNNED: begin
          startNext = hit;
          if (hit) cntNext = STUN_LOAD;
          else if (cnt == '0) begin
`ifdef STUN_IMMUNITY_EN
            stateNext = IMMUNE;
            cntNext = IMM_LOAD;
`else
            stateNext = IDLE;
`endif
          end
          else cntNext = cnt - CNT_W'(1);
        end
`ifdef STUN_IMMUNITY_EN
        IMMUNE: begin
          stateNext = cnt == '0 ? IDLE : IMMUNE;
          cntNext = cnt == '0 ? cnt : cnt - CNT_W'(1);
        end
`endif
        default: stateNext = IDLE;
      endcase
    end
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        state <= IDLE;
        cnt <= '0;
        startQ <= 1'b0;
      end else begin
        state <= stateNext;
        cnt <= cntNext;
        startQ <= startNext;
      end
    end
    assign stunActive[i] = state == STUNNED;
    assign stunStart[i] = startQ;
`ifdef STUN_IMMUNITY_EN
    assign immune[i] = state == IMMUNE;
`endif
  end
`ifndef STUN_IMMUNITY_EN
  assign immune = '0;
`endif
  assign bus.stun_active = stunActive;
  assign bus.stun_start = stunStart;
  assign bus.immune = immune;
endmodule

// File: tb/tb_stun_controller.sv
// tb_stun_controller: directed and random bomb strobes checked against a timestamp model of stun/immunity windows.
module tb_stun_controller;
  localparam int NP = 2, CW = 6, RAD = 1, STUN = 5, IMM = 3;
`ifdef STUN_IMMUNITY_EN
  localparam bit IMM_ON = 1'b1;
`else
  localparam bit IMM_ON = 1'b0;
`endif
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int errors = 0, checks = 0, t = 0;
  int lastHit[NP];
  stun_controller_if #(.NUM_PLAYERS(NP), .COORD_W(CW)) bus ();
  stun_controller #(
    .NUM_PLAYERS(NP), .COORD_W(CW), .RADIUS(RAD),
    .STUN_CYCLES(STUN), .IMMUNE_CYCLES(IMM), .CNT_W(8)
  ) dut (.clk(clk), .resetn(resetn), .bus(bus));
  always #5 clk = ~clk;
  // a player is stunned for the STUN edges starting at its last accepted hit, then immune for IMM edges
  function automatic bit stunnedAt(int i, int j);
    return j >= lastHit[i] && j <= lastHit[i] + STUN - 1;
  endfunction
  function automatic bit immuneAt(int i, int j);
    return IMM_ON && j >= lastHit[i] + STUN && j <= lastHit[i] + STUN + IMM - 1;
  endfunction
  function automatic int absDiff(int a, int b);
    return a > b ? a - b : b - a;
  endfunction
  task automatic chk(input string tag, input logic [NP-1:0] got, input logic [NP-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s t=%0d got=%b exp=%b", tag, t, got, exp);
    end
  endtask
  task automatic modelReset();
    for (int i = 0; i < NP; i++) lastHit[i] = -100000;
  endtask
  task automatic step(input bit bv, input int bx, input int by,
                      input int p0x, input int p0y, input int p1x, input int p1y);
    int px[NP], py[NP];
    logic [NP-1:0] expS, expSt, expI;
    px[0] = p0x; px[1] = p1x; py[0] = p0y; py[1] = p1y;
    bus.bomb_valid = bv;
    bus.bomb_x = CW'(bx);
    bus.bomb_y = CW'(by);
    bus.player_x = {CW'(p1x), CW'(p0x)};
    bus.player_y = {CW'(p1y), CW'(p0y)};
    @(posedge clk);
    t++;
    for (int i = 0; i < NP; i++)
      if (bv && absDiff(px[i], bx) <= RAD && absDiff(py[i], by) <= RAD && !immuneAt(i, t - 1))
        lastHit[i] = t;
    for (int i = 0; i < NP; i++) begin
      expS[i] = stunnedAt(i, t);
      expSt[i] = lastHit[i] == t;
      expI[i] = immuneAt(i, t);
    end
    #1;
    chk("stun_active", bus.stun_active, expS);
    chk("stun_start", bus.stun_start, expSt);
    chk("immune", bus.immune, expI);
    chk("exclusive", bus.stun_active & bus.immune, '0);
  endtask
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 30, 30, 0, 0, 63, 63);
  endtask
  initial begin
    modelReset();
    bus.bomb_valid = 1'b1;
    bus.bomb_x = '0;
    bus.bomb_y = '0;
    bus.player_x = '0;
    bus.player_y = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_stun_active", bus.stun_active, '0);
    chk("reset_stun_start", bus.stun_start, '0);
    chk("reset_immune", bus.immune, '0);
    resetn = 1'b1;
    idle(1);
    step(1, 10, 10, 11, 9, 12, 10);
    idle(6);
    step(1, 0, 0, 63, 0, 1, 1);
    idle(6);
    step(1, 20, 20, 20, 20, 40, 40);
    idle(3);
    step(1, 20, 20, 21, 21, 40, 40);
    idle(4);
    step(1, 20, 20, 19, 19, 40, 40);
    idle(6);
    step(1, 5, 5, 5, 5, 40, 40);
    idle(5);
    step(1, 5, 5, 5, 5, 40, 40);
    idle(1);
    step(1, 5, 5, 5, 5, 40, 40);
    idle(9);
    step(1, 30, 30, 0, 0, 30, 31);
    idle(2);
    #1;
    resetn = 1'b0;
    modelReset();
    #1;
    chk("async_rst_stun_active", bus.stun_active, '0);
    chk("async_rst_stun_start", bus.stun_start, '0);
    chk("async_rst_immune", bus.immune, '0);
    bus.bomb_valid = 1'b1;
    bus.bomb_x = CW'(30);
    bus.bomb_y = CW'(30);
    @(posedge clk);
    t++;
    #1;
    chk("held_rst_stun_active", bus.stun_active, '0);
    chk("held_rst_stun_start", bus.stun_start, '0);
    resetn = 1'b1;
    idle(2);
    for (int k = 0; k < 400; k++) begin
      int e0 = $urandom_range(0, 9) == 0 ? 63 : $urandom_range(0, 5);
      step($urandom_range(0, 2) == 0, $urandom_range(0, 5), $urandom_range(0, 5),
           e0, $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5));
    end
    idle(10);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
